dac_spi_rx: RTL and testbench
=============================

Name: dac_spi_rx

Overview:
- Receive-side model and monitor for the serial DAC link driven by the DAC channel path: SYNC low framing, SCLK, DIN MSB-first.
- Oversamples DAC_SYNC, DAC_SCLK and DAC_DIN on dataclk and rebuilds each frame.
- Presents the decoded 16-bit DAC code, the power-down bits and frame status to the debug bench and to on-chip loopback checks.
- Sits beside the DAC serializer; it never drives the link.

Parameters:
- FRAME_BITS, 24: SCLK falling edges per complete frame.
- DATA_BITS, 16: width of the DAC code field, located in the LSBs of the frame.
- PD_LSB, 16: bit position of the 2-bit power-down field, frame bits [PD_LSB+1:PD_LSB]. Requires FRAME_BITS >= PD_LSB+2.

Ports:
- dataclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- DAC_SYNC  in  1  frame strobe; active low.
- DAC_SCLK  in  1  serial clock; DIN is sampled on its falling edge.
- DAC_DIN  in  1  serial data, MSB first.
- DAC_rx_data  out  DATA_BITS  last complete frame, bits [DATA_BITS-1:0].
- DAC_rx_pd  out  2  last complete frame, bits [PD_LSB+1:PD_LSB].
- DAC_rx_valid  out  1  one-cycle pulse when DAC_rx_data/DAC_rx_pd update.
- DAC_rx_abort  out  1  one-cycle pulse when a frame ends short.
- DAC_rx_busy  out  1  high while in SHIFT or FULL.
- DAC_rx_frame_count  out  16  count of complete frames; wraps 0xFFFF -> 0.
- DAC_rx_state  out  2  current state code, for debug.

Behaviour:
- Reset: all outputs are 0; state is IDLE; shift register and bit counter are 0; previous-sample registers for SYNC and SCLK are 1.
- Sampling: the previous sample of SYNC and SCLK is registered every cycle.
  - sync_fall = prev 1 and current 0.
  - sync_rise = prev 0 and current 1.
  - sclk_fall = prev 1 and current 0.
- State machine:
  - IDLE (0): on sync_fall -> SHIFT; clear bit_cnt and the shift register.
  - SHIFT (1): on sclk_fall with current SYNC=0, shift {shreg, DIN} and increment bit_cnt. When the edge is the FRAME_BITS-th -> FULL.
  - SHIFT: on sync_rise before FRAME_BITS edges -> pulse DAC_rx_abort the next cycle, return to IDLE. Data registers and counter are unchanged.
  - FULL (2): on the first cycle, load DAC_rx_data and DAC_rx_pd from the shift register, pulse DAC_rx_valid and increment DAC_rx_frame_count. All further sclk_fall edges are ignored. On sync_rise -> IDLE.
  - Code 3 is unused; if reached, go to IDLE the next cycle with no pulses.
- Latency: DAC_rx_valid is asserted 2 dataclk cycles after the sampled SCLK falling edge that carries the last bit (1 cycle edge detect, 1 cycle load).
- Coincident events:
  - An SCLK fall in the same sample as a SYNC fall is not counted; SHIFT is entered on the next cycle.
  - An SCLK fall in the same sample as a SYNC rise is not counted; the sync_rise is handled.
- Immediate refram: sync_fall seen in FULL, or in IDLE the cycle SYNC rose, starts a new frame normally. A back-to-back frame with SYNC high for one sample is legal.
- SYNC held low forever: the block stays in FULL; no further outputs.
- Reset mid-frame: discards partial data and returns to the reset values above, including DAC_rx_frame_count = 0.
- DAC_rx_busy is high in SHIFT and FULL.
- SCLK must be at least 2 dataclk cycles high and 2 low; faster SCLK is out of spec and edges may be lost.

Optional Feature:
- Macro: DAC_SPI_RX_SYNC_EN.
- Defined: DAC_SYNC, DAC_SCLK and DAC_DIN each pass through a 2-flop synchronizer before edge detection. Synchronizer flops reset to 1, 1, 0. All latencies grow by 2 cycles; frame behaviour is otherwise identical. Used when the link comes from an external pin or another clock domain.
- Undefined: inputs are sampled directly. Valid only when the link is generated from dataclk, as it is on-chip.

Test Plan:
- Reset, then one 24-bit frame 0x03_ABCD (SCLK 4 cycles/bit) -> DAC_rx_data=0xABCD, DAC_rx_pd=2'b11, one DAC_rx_valid pulse 2 cycles after the 24th SCLK fall, frame_count=1.
- SYNC rises after 10 edges -> single DAC_rx_abort pulse; data/pd/count keep their previous values; state returns to 0.
- Frame 0x00_1234, then 4 extra SCLK falls with SYNC low, then SYNC high -> only one valid pulse; data=0x1234; the extra bits are ignored.
- Two frames 0x00_8000 then 0x00_7FFF with SYNC high for one sample between them -> two valid pulses, data in that order, count=2.
- Reset asserted after 12 bits of frame 0x00_FFFF -> all outputs 0 the next cycle; a following frame 0x00_0001 decodes as data=0x0001, count=1.
- Preload count to 0xFFFF via 65535 frames (or force), then one more frame -> count wraps to 0x0000. With DAC_SPI_RX_SYNC_EN defined, the first scenario's valid pulse moves to 4 cycles after the last edge.

Source files
------------

// File: rtl/dac_spi_rx.sv
//==============================================================================
// Module  : dac_spi_rx
// Brief   : Oversampling receiver/monitor for the SYNC/SCLK/DIN DAC link.
//           Define DAC_SPI_RX_SYNC_EN to add 2-flop input synchronizers.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dac_spi_rx #(
    parameter int FRAME_BITS = 24,
    parameter int DATA_BITS  = 16,
    parameter int PD_LSB     = 16
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic                 DAC_SYNC,
    input  logic                 DAC_SCLK,
    input  logic                 DAC_DIN,
    output logic [DATA_BITS-1:0] DAC_rx_data,
    output logic [1:0]           DAC_rx_pd,
    output logic                 DAC_rx_valid,
    output logic                 DAC_rx_abort,
    output logic                 DAC_rx_busy,
    output logic [15:0]          DAC_rx_frame_count,
    output logic [1:0]           DAC_rx_state
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    logic w_sync;
    logic w_sclk;
    logic w_din;

`ifdef DAC_SPI_RX_SYNC_EN
    logic [1:0] sync_ff_q;
    logic [1:0] sclk_ff_q;
    logic [1:0] din_ff_q;

    always_ff @(posedge dataclk) begin
        if (reset) begin
            sync_ff_q <= 2'b11;
            sclk_ff_q <= 2'b11;
            din_ff_q  <= 2'b00;
        end else begin
            sync_ff_q <= {sync_ff_q[0], DAC_SYNC};
            sclk_ff_q <= {sclk_ff_q[0], DAC_SCLK};
            din_ff_q  <= {din_ff_q[0], DAC_DIN};
        end
    end

    assign w_sync = sync_ff_q[1];
    assign w_sclk = sclk_ff_q[1];
    assign w_din  = din_ff_q[1];
`else
    assign w_sync = DAC_SYNC;
    assign w_sclk = DAC_SCLK;
    assign w_din  = DAC_DIN;
`endif

    state_t                state_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  sync_prev_q;
    logic                  sclk_prev_q;
    logic                  first_q;
    logic [DATA_BITS-1:0]  data_q;
    logic [1:0]            pd_q;
    logic                  valid_q;
    logic                  abort_q;
    logic [15:0]           frame_cnt_q;

    logic w_sync_fall;
    logic w_sync_rise;
    logic w_sclk_fall;
    logic w_unused_msb;

    assign w_sync_fall  = sync_prev_q & ~w_sync;
    assign w_sync_rise  = ~sync_prev_q & w_sync;
    assign w_sclk_fall  = sclk_prev_q & ~w_sclk;
    assign w_unused_msb = shreg_q[FRAME_BITS-1];

    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sync_prev_q <= 1'b1;
            sclk_prev_q <= 1'b1;
            first_q     <= 1'b0;
            data_q      <= '0;
            pd_q        <= '0;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sync_prev_q <= w_sync;
            sclk_prev_q <= w_sclk;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_sync_fall) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                    end
                end

                ST_SHIFT: begin
                    // A SYNC rise wins over a coincident SCLK fall.
                    if (w_sync_rise) begin
                        abort_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (w_sclk_fall && !w_sync) begin
                        shreg_q   <= {shreg_q[FRAME_BITS-2:0], w_din};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == C_LAST_BIT) begin
                            state_q <= ST_FULL;
                            first_q <= 1'b1;
                        end
                    end
                end

                ST_FULL: begin
                    first_q <= 1'b0;
                    if (first_q) begin
                        data_q      <= shreg_q[DATA_BITS-1:0];
                        pd_q        <= shreg_q[PD_LSB+1:PD_LSB];
                        valid_q     <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                    if (w_sync_rise) begin
                        state_q <= ST_IDLE;
                    end else if (w_sync_fall) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    assign DAC_rx_data        = data_q;
    assign DAC_rx_pd          = pd_q;
    assign DAC_rx_valid       = valid_q;
    assign DAC_rx_abort       = abort_q;
    assign DAC_rx_busy        = (state_q == ST_SHIFT) || (state_q == ST_FULL);
    assign DAC_rx_frame_count = frame_cnt_q;
    assign DAC_rx_state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_rx.sv
//==============================================================================
// Module  : tb_dac_spi_rx
// Brief   : Randomized self-checking bench for dac_spi_rx against a frame-level
//           reference model. Honours DAC_SPI_RX_SYNC_EN for latency.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dac_spi_rx;

`ifdef DAC_SPI_RX_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif

    logic        dataclk  = 1'b0;
    logic        reset    = 1'b1;
    logic        DAC_SYNC = 1'b1;
    logic        DAC_SCLK = 1'b1;
    logic        DAC_DIN  = 1'b0;
    logic [15:0] DAC_rx_data;
    logic [1:0]  DAC_rx_pd;
    logic        DAC_rx_valid;
    logic        DAC_rx_abort;
    logic        DAC_rx_busy;
    logic [15:0] DAC_rx_frame_count;
    logic [1:0]  DAC_rx_state;

    dac_spi_rx dut (
        .dataclk           (dataclk),
        .reset             (reset),
        .DAC_SYNC          (DAC_SYNC),
        .DAC_SCLK          (DAC_SCLK),
        .DAC_DIN           (DAC_DIN),
        .DAC_rx_data       (DAC_rx_data),
        .DAC_rx_pd         (DAC_rx_pd),
        .DAC_rx_valid      (DAC_rx_valid),
        .DAC_rx_abort      (DAC_rx_abort),
        .DAC_rx_busy       (DAC_rx_busy),
        .DAC_rx_frame_count(DAC_rx_frame_count),
        .DAC_rx_state      (DAC_rx_state)
    );

    always #5 dataclk = ~dataclk;

    int cyc = 0;
    always @(posedge dataclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          is_valid;
        int          at_cyc;
        logic [15:0] data;
        logic [1:0]  pd;
        logic [15:0] cnt;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] m_data = '0;
    logic [1:0]  m_pd   = '0;
    logic [15:0] m_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every pulse the DUT emits must match the head of the expected-event queue.
    always @(negedge dataclk) begin
        ev_t e;
        if (!reset) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].at_cyc) begin
                check("pulse_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            if (DAC_rx_valid || DAC_rx_abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, DAC_rx_valid, DAC_rx_abort}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.at_cyc);
                    check("valid", {31'd0, DAC_rx_valid}, {31'd0, e.is_valid});
                    check("abort", {31'd0, DAC_rx_abort}, {31'd0, !e.is_valid});
                    check("data", {16'd0, DAC_rx_data}, {16'd0, e.data});
                    check("pd", {30'd0, DAC_rx_pd}, {30'd0, e.pd});
                    check("frame_count", {16'd0, DAC_rx_frame_count}, {16'd0, e.cnt});
                end
            end
        end
    end

    function automatic ev_t make_ev(input bit is_valid, input int at_cyc);
        ev_t e;
        e.is_valid = is_valid;
        e.at_cyc   = at_cyc;
        e.data     = m_data;
        e.pd       = m_pd;
        e.cnt      = m_cnt;
        return e;
    endfunction

    // Frame-level model: >= 24 edges decode the first 24 bits, fewer abort.
    task automatic send_frame(input logic [23:0] bits, input int nedges, input int hi,
                              input int lo, input int gap, input bit coinc);
        @(negedge dataclk);
        DAC_SYNC = 1'b0;
        if (coinc) begin
            DAC_SCLK = 1'b0;
            repeat (2) @(negedge dataclk);
            DAC_SCLK = 1'b1;
        end
        repeat (2) @(negedge dataclk);
        for (int i = 0; i < nedges; i++) begin
            DAC_DIN = (i < 24) ? bits[23 - i] : 1'($urandom_range(0, 1));
            repeat (hi) @(negedge dataclk);
            DAC_SCLK = 1'b0;
            if (i == 23) begin
                m_data = bits[15:0];
                m_pd   = bits[17:16];
                m_cnt  = m_cnt + 16'd1;
                exp_q.push_back(make_ev(1'b1, cyc + 2 + c_LAT));
            end
            repeat (lo) @(negedge dataclk);
            DAC_SCLK = 1'b1;
        end
        repeat (2) @(negedge dataclk);
        DAC_SYNC = 1'b1;
        if (nedges < 24) exp_q.push_back(make_ev(1'b0, cyc + 1 + c_LAT));
        repeat (gap - 1) @(negedge dataclk);
    endtask

    task automatic settle();
        repeat (10) @(negedge dataclk);
        check("pending_events", exp_q.size(), 32'd0);
        check("idle_state", {30'd0, DAC_rx_state}, 32'd0);
        check("idle_busy", {31'd0, DAC_rx_busy}, 32'd0);
    endtask

    task automatic frame(input logic [23:0] bits, input int nedges);
        send_frame(bits, nedges, 2, 2, 1, 1'b0);
        settle();
    endtask

    initial begin
        int ne;
        int pick;
        repeat (3) @(negedge dataclk);
        check("rst_data", {16'd0, DAC_rx_data}, 32'd0);
        check("rst_pd", {30'd0, DAC_rx_pd}, 32'd0);
        check("rst_valid_abort", {30'd0, DAC_rx_valid, DAC_rx_abort}, 32'd0);
        check("rst_busy_state", {29'd0, DAC_rx_busy, DAC_rx_state}, 32'd0);
        check("rst_count", {16'd0, DAC_rx_frame_count}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge dataclk);

        frame(24'h03ABCD, 24);
        frame(24'h03ABCD, 10);
        frame(24'h001234, 28);
        send_frame(24'h008000, 24, 2, 2, 1, 1'b0);
        send_frame(24'h007FFF, 24, 2, 2, 1, 1'b0);
        settle();
        send_frame(24'h02C3C3, 24, 3, 2, 1, 1'b1);
        settle();

        // Reset in the middle of a frame discards everything.
        @(negedge dataclk);
        DAC_SYNC = 1'b0;
        repeat (2) @(negedge dataclk);
        for (int i = 0; i < 12; i++) begin
            DAC_DIN = 1'b1;
            repeat (2) @(negedge dataclk);
            DAC_SCLK = 1'b0;
            repeat (2) @(negedge dataclk);
            DAC_SCLK = 1'b1;
        end
        reset    = 1'b1;
        DAC_SYNC = 1'b1;
        @(negedge dataclk);
        check("midrst_data", {16'd0, DAC_rx_data}, 32'd0);
        check("midrst_pd_busy_state", {27'd0, DAC_rx_pd, DAC_rx_busy, DAC_rx_state}, 32'd0);
        check("midrst_count", {16'd0, DAC_rx_frame_count}, 32'd0);
        m_data = '0;
        m_pd   = '0;
        m_cnt  = '0;
        reset  = 1'b0;
        repeat (2) @(negedge dataclk);
        frame(24'h000001, 24);

        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        frame(24'h015A5A, 24);
        check("wrap_count", {16'd0, DAC_rx_frame_count}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 70)      ne = 24;
            else if (pick < 85) ne = int'($urandom_range(1, 23));
            else                ne = int'($urandom_range(25, 28));
            send_frame(24'($urandom), ne, int'($urandom_range(2, 4)), int'($urandom_range(2, 4)),
                       int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            if (k % 8 == 7) settle();
        end
        settle();
        check("final_count", {16'd0, DAC_rx_frame_count}, {16'd0, m_cnt});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
